tile_hash_gen: RTL and testbench
================================

Name: tile_hash_gen

Overview:
- Sits directly downstream of vram_snooper and consumes its per-tile byte stream (hash_data_valid / hash_data / hash_data_last).
- Computes a 32-bit FNV-1a hash over each tile.
- Queues {hash, tile index, text flag} in a small output FIFO for the translation-lookup stage.
- Input has no backpressure: the block accepts one byte every cycle unconditionally.

Parameters:
- OUT_DEPTH, 4, output FIFO depth in entries; power of two, 2 or more.
- TILE_BYTES, 16, expected bytes per tile; used only by the optional length check.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  byte strobe; connects to snooper hash_data_valid.
- in_data  in  8  byte value; connects to hash_data.
- in_last  in  1  final byte of the tile; connects to hash_data_last.
- in_tile_index  in  9  tile index from the snooper; sampled on the last-byte cycle.
- in_is_text  in  1  text-region flag from the snooper; sampled on the last-byte cycle.
- cfg_enable  in  1  block enable.
- cfg_text_only  in  1  when 1, discard hashes of non-text tiles.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head entry.
- out_hash  out  32  hash of the head entry.
- out_tile_index  out  9  tile index of the head entry.
- out_is_text  out  1  text flag of the head entry.
- busy  out  1  a tile is partially accumulated.
- stat_overflow  out  1  sticky: a hash was lost because the FIFO was full.
- stat_drop_count  out  16  saturating count of lost hashes.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - All outputs go to 0; FIFO empty; state IDLE.
  - Accumulator = 0x811C9DC5; byte counter = 0.
  - Reset mid-tile discards the partial tile.
- States:
  - IDLE: no bytes received yet.
  - ACCUM: at least one byte received, last byte not yet seen; busy = 1 only in ACCUM.
- Per accepted byte (in_valid & cfg_enable):
  - h_next = (h ^ in_data) * 0x01000193 mod 2^32.
  - Multiply built from shift-adds: h + h<<1 + h<<4 + h<<7 + h<<8 + h<<24.
  - h is the seed 0x811C9DC5 on the first byte of a tile.
  - Byte counter increments, saturating at 31.
- State transitions:
  - IDLE -> ACCUM on a byte with in_last = 0.
  - ACCUM -> ACCUM on further bytes.
  - Any state -> IDLE on a byte with in_last = 1; accumulator re-seeded, counter cleared.
  - Single-byte tiles (in_valid & in_last while IDLE) are legal.
- Completion on the last-byte cycle:
  - The final hash includes that byte.
  - {h_next, in_tile_index, in_is_text} is registered into the FIFO at that edge.
  - out_valid rises the following cycle when the FIFO was empty (latency 1 from the last byte).
- Text filter: if cfg_text_only = 1 and in_is_text = 0 at completion, the result is discarded silently; no stat change.
- FIFO:
  - A pop occurs when out_valid & out_ready.
  - Push while full with a simultaneous pop: push accepted, count unchanged.
  - Push while full without a pop: entry lost; stat_overflow set; stat_drop_count increments, saturating at 0xFFFF.
  - Pointers wrap modulo OUT_DEPTH; ordering is strictly FIFO.
  - Head outputs stay stable while out_valid = 1 and out_ready = 0.
- cfg_enable = 0:
  - in_valid is ignored.
  - Any partial tile is aborted: return to IDLE, re-seed accumulator.
  - FIFO contents stay poppable; stats are held.
- Stats clear only on reset.

Optional Feature:
- Macro: TILE_HASH_LEN_CHECK_EN.
- Defined:
  - At completion, if the byte count (including the last byte) differs from TILE_BYTES, the hash is discarded.
  - Sticky output stat_len_err (1 bit, reset 0) is added and set.
  - A byte count exceeding TILE_BYTES with no in_last also sets stat_len_err; the tile continues until in_last and is then discarded.
- Undefined:
  - No stat_len_err port; any length is hashed.
  - The byte counter may be omitted.

Decomposition:
- Package tile_hash_pkg holds:
  - FNV_OFFSET = 32'h811C9DC5 and FNV_PRIME = 32'h01000193.
  - Function fnv1a_step(hash, byte).
  - Typedefs tile_idx_t (9 bits), hash_t (32 bits), and packed struct hash_entry_t {hash, tile_index, is_text}.
- One sub-module: hash_out_fifo, a synchronous FIFO of hash_entry_t parameterised by OUT_DEPTH, with full/empty, push/pop and simultaneous push/pop-when-full support.

Test Plan:
- Single byte 0x61 with in_last, tile 5, out_ready = 1 -> one cycle later out_valid = 1, out_hash = 0xE40C292C, out_tile_index = 5.
- Bytes 66 6F 6F 62 61 72 (last on 0x72), tile 64, in_is_text = 1 -> out_hash = 0xBF9CF968, out_is_text = 1; busy high for 5 cycles.
- cfg_text_only = 1, 16-byte tile 200 with in_is_text = 0 -> out_valid stays 0; stat_drop_count = 0.
- out_ready = 0, OUT_DEPTH = 4, six tiles sent -> first four retained in order; stat_overflow = 1; stat_drop_count = 2. Release out_ready -> four pops in order, then out_valid = 0.
- cfg_enable dropped after byte 7 of a tile, re-enabled, then single byte 0x61 -> hash 0xE40C292C (accumulator re-seeded).
- With TILE_HASH_LEN_CHECK_EN, a 15-byte tile -> no output, stat_len_err = 1. A following 16-byte tile -> output produced normally.

Source files
------------

// File: rtl/tile_hash_gen_pkg.sv
// tile_hash_pkg: shared types and helpers for the tile hash generator.
//   FNV_OFFSET / FNV_PRIME : 32-bit FNV-1a constants
//   fnv1a_step()           : one FNV-1a byte step (multiply as shift-adds)
//   hash_entry_t           : {hash, tile_index, is_text} queued per tile
package tile_hash_pkg;

   localparam logic [31:0] FNV_OFFSET = 32'h811C9DC5;
   localparam logic [31:0] FNV_PRIME  = 32'h01000193;

   typedef logic [8:0]  tile_idx_t;
   typedef logic [31:0] hash_t;

   typedef struct packed {
      hash_t     hash;
      tile_idx_t tile_index;
      logic      is_text;
   } hash_entry_t;

   typedef enum logic {IDLE, ACCUM} hg_state_t;

   // FNV_PRIME = 2^24 + 2^8 + 2^7 + 2^4 + 2^1 + 2^0, so the multiply
   // collapses to six shifted terms summed mod 2^32.
   function automatic hash_t fnv1a_step(input hash_t h, input logic [7:0] b);
      hash_t x;
      x = h ^ {24'd0, b};
      return x + (x << 1) + (x << 4) + (x << 7) + (x << 8) + (x << 24);
   endfunction

endpackage

// File: rtl/tile_hash_gen_fifo.sv
// hash_out_fifo: synchronous FIFO of hash_entry_t.
//   clk, rst_n   : clock, synchronous active-low reset (contents cleared)
//   push_i/data  : enqueue request; accepted when not full or when popping
//   pop_i        : dequeue request; ignored when empty
//   head_o       : current head entry
//   full_o/empty_o
module hash_out_fifo
   import tile_hash_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push_i,
   input  hash_entry_t push_data_i,
   input  logic        pop_i,
   output hash_entry_t head_o,
   output logic        full_o,
   output logic        empty_o
);

   localparam int AW = $clog2(DEPTH);

   hash_entry_t     mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     cnt_q;
   logic            do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i & ~empty_o;
   // A pop in the same cycle frees the slot the push lands in.
   assign do_push = push_i & (~full_o | do_pop);
   assign head_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;   // power-of-two depth wraps
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/tile_hash_gen.sv
// tile_hash_gen: FNV-1a 32-bit hash per tile of the snooper byte stream,
// queued as {hash, tile index, text flag} for the translation lookup.
//   in_valid/in_data/in_last : byte stream, no backpressure
//   in_tile_index/in_is_text : tile tags, sampled on the last byte
//   cfg_enable               : 0 ignores input and aborts any partial tile
//   cfg_text_only            : drop hashes of non-text tiles
//   out_valid/out_ready/out_*: FIFO head handshake
//   busy                     : a tile is partially accumulated
//   stat_overflow/stat_drop_count : sticky loss flag, saturating loss count
// Optional build macro TILE_HASH_LEN_CHECK_EN: tiles whose length is not
// TILE_BYTES are discarded and flagged on stat_len_err.
module tile_hash_gen
   import tile_hash_pkg::*;
#(
   parameter int OUT_DEPTH  = 4,
   parameter int TILE_BYTES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   input  logic [8:0]  in_tile_index,
   input  logic        in_is_text,
   input  logic        cfg_enable,
   input  logic        cfg_text_only,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_hash,
   output logic [8:0]  out_tile_index,
   output logic        out_is_text,
   output logic        busy,
   output logic        stat_overflow,
   output logic [15:0] stat_drop_count
`ifdef TILE_HASH_LEN_CHECK_EN
  ,output logic        stat_len_err
`endif
);

   // Byte counter saturates at 31, so the length check needs TILE_BYTES <= 30.
   if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("OUT_DEPTH must be a power of two >= 2");
   end
   if (TILE_BYTES < 1 || TILE_BYTES > 30) begin : g_bad_len
      $error("TILE_BYTES must be in 1..30");
   end

   hg_state_t   state_q;
   hash_t       acc_q, h_next;
   logic        accept, complete, len_bad, push, pop;
   logic        fifo_full, fifo_empty;
   logic [15:0] drop_d;
   hash_entry_t push_entry, head;

   assign accept   = in_valid & cfg_enable;
   assign complete = accept & in_last;
   // Accumulator is always re-seeded on return to IDLE, so it already holds
   // the offset basis for the first byte of a tile.
   assign h_next   = fnv1a_step(acc_q, in_data);
   assign busy     = (state_q == ACCUM);

`ifdef TILE_HASH_LEN_CHECK_EN
   logic [4:0] cnt_q, cnt_inc;
   logic       len_err_q;

   assign cnt_inc = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
   assign len_bad = (cnt_inc != 5'(TILE_BYTES));
   assign stat_len_err = len_err_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         len_err_q <= 1'b0;
      end else begin
         if (!cfg_enable || complete) cnt_q <= '0;
         else if (accept)             cnt_q <= cnt_inc;
         // Flag both a short/long completed tile and an overrun still in flight.
         if (complete && len_bad) len_err_q <= 1'b1;
         if (accept && !in_last && cnt_inc > 5'(TILE_BYTES)) len_err_q <= 1'b1;
      end
   end
`else
   assign len_bad = 1'b0;
`endif

   // FSM: any state returns to IDLE on the last byte or on disable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= FNV_OFFSET;
      end else if (!cfg_enable || complete) begin
         state_q <= IDLE;
         acc_q   <= FNV_OFFSET;
      end else if (accept) begin
         state_q <= ACCUM;
         acc_q   <= h_next;
      end
   end

   assign push = complete & ~(cfg_text_only & ~in_is_text) & ~len_bad;
   assign pop  = out_valid & out_ready;
   assign push_entry = '{hash: h_next, tile_index: in_tile_index, is_text: in_is_text};

   hash_out_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign out_valid      = ~fifo_empty;
   assign out_hash       = head.hash;
   assign out_tile_index = head.tile_index;
   assign out_is_text    = head.is_text;

   assign drop_d = (stat_drop_count == 16'hFFFF) ? stat_drop_count : stat_drop_count + 16'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_overflow   <= 1'b0;
         stat_drop_count <= '0;
      end else if (push && fifo_full && !pop) begin
         stat_overflow   <= 1'b1;
         stat_drop_count <= drop_d;
      end
   end

endmodule

// File: tb/tb_tile_hash_gen.sv
module tb_tile_hash_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_last = 1'b0;
   logic [8:0]  in_tile_index = '0;
   logic        in_is_text = 1'b0;
   logic        cfg_enable = 1'b1;
   logic        cfg_text_only = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_hash;
   logic [8:0]  out_tile_index;
   logic        out_is_text;
   logic        busy;
   logic        stat_overflow;
   logic [15:0] stat_drop_count;
`ifdef TILE_HASH_LEN_CHECK_EN
   localparam bit LEN_CHK = 1'b1;
   logic        stat_len_err;
`else
   localparam bit LEN_CHK = 1'b0;
`endif

   tile_hash_gen #(.OUT_DEPTH(4), .TILE_BYTES(16)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_data         (in_data),
      .in_last         (in_last),
      .in_tile_index   (in_tile_index),
      .in_is_text      (in_is_text),
      .cfg_enable      (cfg_enable),
      .cfg_text_only   (cfg_text_only),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_hash        (out_hash),
      .out_tile_index  (out_tile_index),
      .out_is_text     (out_is_text),
      .busy            (busy),
      .stat_overflow   (stat_overflow),
      .stat_drop_count (stat_drop_count)
`ifdef TILE_HASH_LEN_CHECK_EN
     ,.stat_len_err    (stat_len_err)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int busy_cnt;

   typedef logic [31:0][7:0] buf_t;

   typedef struct {
      buf_t        d;
      int          n;
      int          idx;
      bit          txt;
      bit          txt_only;
      bit          exp_out;
      bit          use_model;
      logic [31:0] hash;
   } vec_t;

   vec_t vt[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference FNV-1a using a true multiply.
   function automatic logic [31:0] fnv_ref(input buf_t b, input int n);
      logic [31:0] h;
      h = 32'h811C9DC5;
      for (int i = 0; i < n; i++) h = (h ^ {24'd0, b[i]}) * 32'h01000193;
      return h;
   endfunction

   function automatic buf_t pat(input int n, input int idx);
      buf_t b;
      b = '0;
      for (int i = 0; i < n; i++) b[i] = 8'(idx + 3 * i + 1);
      return b;
   endfunction

   function automatic vec_t mk(input string s, input int idx, input bit txt,
                               input bit to, input bit eo, input logic [31:0] h);
      vec_t v;
      v.d = '0;
      for (int i = 0; i < s.len(); i++) v.d[i] = s[i];
      v.n = s.len(); v.idx = idx; v.txt = txt; v.txt_only = to;
      v.exp_out = eo; v.use_model = 1'b0; v.hash = h;
      return v;
   endfunction

   function automatic vec_t mkm(input int n, input int idx, input bit txt,
                                input bit to, input bit eo);
      vec_t v;
      v.d = pat(n, idx);
      v.n = n; v.idx = idx; v.txt = txt; v.txt_only = to;
      v.exp_out = eo; v.use_model = 1'b1; v.hash = fnv_ref(v.d, n);
      return v;
   endfunction

   task automatic send_tile(input buf_t b, input int n, input int idx,
                            input bit txt, input bit rdy_last);
      busy_cnt = 0;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1; in_data = b[i]; in_last = (i == n - 1);
         in_tile_index = 9'(idx); in_is_text = txt;
         out_ready = rdy_last && (i == n - 1);
         step();
         if (busy) busy_cnt++;
      end
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      step(); step();
      rst_n = 1'b1;
   endtask

   initial begin
      bit   eo;
      buf_t b;

      vt[0] = mk("a",      5,   1'b0, 1'b0, 1'b1, 32'hE40C292C);
      vt[1] = mk("foobar", 64,  1'b1, 1'b0, 1'b1, 32'hBF9CF968);
      vt[2] = mk("ab",     7,   1'b0, 1'b0, 1'b1, 32'h4D2505CA);
      vt[3] = mk("abc",    300, 1'b1, 1'b1, 1'b1, 32'h1A47E90B);
      vt[4] = mk("a",      6,   1'b0, 1'b1, 1'b0, 32'h0);
      vt[5] = mkm(16, 200, 1'b0, 1'b1, 1'b0);
      vt[6] = mkm(16, 201, 1'b1, 1'b1, 1'b1);
      vt[7] = mkm(16, 511, 1'b0, 1'b0, 1'b1);

      // Reset state
      do_reset();
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst overflow", 32'(stat_overflow), 32'd0);
      chk("rst drop", 32'(stat_drop_count), 32'd0);
      chk("rst out_hash", out_hash, 32'd0);
      chk("rst out_idx", 32'(out_tile_index), 32'd0);

      // Table-driven tiles
      for (int k = 0; k < 8; k++) begin
         cfg_text_only = vt[k].txt_only;
         eo = vt[k].exp_out && (!LEN_CHK || vt[k].n == 16);
         send_tile(vt[k].d, vt[k].n, vt[k].idx, vt[k].txt, 1'b0);
         chk($sformatf("v%0d busy cycles", k), 32'(busy_cnt), 32'(vt[k].n - 1));
         chk($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(eo));
         if (eo) begin
            chk($sformatf("v%0d hash", k), out_hash, vt[k].hash);
            chk($sformatf("v%0d idx", k), 32'(out_tile_index), 32'(vt[k].idx));
            chk($sformatf("v%0d text", k), 32'(out_is_text), 32'(vt[k].txt));
            pop_one();
            chk($sformatf("v%0d empty after pop", k), 32'(out_valid), 32'd0);
         end
      end
      cfg_text_only = 1'b0;
      chk("filter drop count", 32'(stat_drop_count), 32'd0);
      chk("filter overflow", 32'(stat_overflow), 32'd0);

      // Overflow: six tiles into a depth-4 FIFO with no consumer
      for (int k = 0; k < 6; k++) send_tile(pat(16, 20 + k), 16, 20 + k, 1'b1, 1'b0);
      chk("ovf sticky", 32'(stat_overflow), 32'd1);
      chk("ovf drop count", 32'(stat_drop_count), 32'd2);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("ovf pop%0d valid", k), 32'(out_valid), 32'd1);
         chk($sformatf("ovf pop%0d idx", k), 32'(out_tile_index), 32'(20 + k));
         chk($sformatf("ovf pop%0d hash", k), out_hash, fnv_ref(pat(16, 20 + k), 16));
         pop_one();
      end
      chk("ovf drained", 32'(out_valid), 32'd0);

      // Push into a full FIFO with a simultaneous pop: nothing lost
      for (int k = 0; k < 4; k++) send_tile(pat(16, 30 + k), 16, 30 + k, 1'b0, 1'b0);
      send_tile(pat(16, 34), 16, 34, 1'b0, 1'b1);
      chk("full+pop drop count", 32'(stat_drop_count), 32'd2);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("full+pop %0d idx", k), 32'(out_tile_index), 32'(31 + k));
         pop_one();
      end
      chk("full+pop drained", 32'(out_valid), 32'd0);

      // Disable mid-tile after 7 bytes, ignored bytes while disabled
      b = pat(16, 90);
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1; in_data = b[i]; in_last = 1'b0; in_tile_index = 9'd90;
         step();
      end
      chk("pre-disable busy", 32'(busy), 32'd1);
      cfg_enable = 1'b0;
      in_data = 8'hAA; in_last = 1'b1;
      step(); step();
      in_valid = 1'b0; in_last = 1'b0;
      chk("disabled busy", 32'(busy), 32'd0);
      chk("disabled no push", 32'(out_valid), 32'd0);
      cfg_enable = 1'b1;
      send_tile(pat(16, 99), 16, 99, 1'b1, 1'b0);
      chk("reseed valid", 32'(out_valid), 32'd1);
      chk("reseed hash", out_hash, fnv_ref(pat(16, 99), 16));
      pop_one();
      if (!LEN_CHK) begin
         send_tile(vt[0].d, 1, 5, 1'b0, 1'b0);
         chk("reseed single a", out_hash, 32'hE40C292C);
         pop_one();
      end

      // Reset mid-tile discards the partial hash
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 8'h55; in_last = 1'b0; step();
      end
      do_reset();
      chk("mid rst busy", 32'(busy), 32'd0);
      chk("mid rst drop clr", 32'(stat_drop_count), 32'd0);
      send_tile(pat(16, 77), 16, 77, 1'b0, 1'b0);
      chk("post rst hash", out_hash, fnv_ref(pat(16, 77), 16));
      pop_one();

`ifdef TILE_HASH_LEN_CHECK_EN
      do_reset();
      chk("len_err reset", 32'(stat_len_err), 32'd0);
      send_tile(pat(15, 40), 15, 40, 1'b0, 1'b0);
      chk("len15 no out", 32'(out_valid), 32'd0);
      chk("len15 err", 32'(stat_len_err), 32'd1);
      send_tile(pat(16, 41), 16, 41, 1'b0, 1'b0);
      chk("len16 valid", 32'(out_valid), 32'd1);
      chk("len16 hash", out_hash, fnv_ref(pat(16, 41), 16));
      pop_one();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
